// File: rtl/mult_pkg.sv
// -----------------------------------------------------------------------------
// mult_pkg
// Shared definitions for the radix-4 Booth / Wallace-tree multiplier:
//   - Booth select-vector bit positions (neg, one, two)
//   - npp(width): number of Booth digits / partial-product rows
//   - pw(width):  product width
//   - booth_sel(win): maps a 3-bit Booth window to its select vector
// -----------------------------------------------------------------------------
package mult_pkg;

   // Bit positions inside the 3-bit Booth select vector
   localparam int BOOTH_NEG = 2;
   localparam int BOOTH_ONE = 1;
   localparam int BOOTH_TWO = 0;

   function automatic int npp(input int width);
      return width / 2 + 1;
   endfunction

   function automatic int pw(input int width);
      return 2 * width;
   endfunction

   // Window {b[2i+1], b[2i], b[2i-1]} -> digit in {-2,-1,0,+1,+2}.
   // 111 is -0 and is encoded as plain zero so no negation is applied.
   function automatic logic [2:0] booth_sel(input logic [2:0] win);
      logic [2:0] sel;
      sel            = '0;
      sel[BOOTH_NEG] = win[2] & ~(win[1] & win[0]);
      sel[BOOTH_ONE] = win[1] ^ win[0];
      sel[BOOTH_TWO] = (win[2] & ~win[1] & ~win[0]) | (~win[2] & win[1] & win[0]);
      return sel;
   endfunction

endpackage

// File: rtl/booth4_pp_row.sv
// -----------------------------------------------------------------------------
// booth4_pp_row
// One radix-4 Booth partial-product row (unshifted).
// Ports:
//   win   in  3         Booth window {b[2i+1], b[2i], b[2i-1]}
//   a_ext in  WIDTH+2   multiplicand, already sign/zero extended
//   row   out 2*WIDTH   digit * a_ext, sign-extended to product width
// -----------------------------------------------------------------------------
module booth4_pp_row
   import mult_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic [2:0]         win,
   input  logic [WIDTH+1:0]   a_ext,
   output logic [2*WIDTH-1:0] row
);

   // One extra bit over a_ext holds 2*a without overflow
   localparam int RW = WIDTH + 3;

   logic [2:0]    sel;
   logic [RW-1:0] mag;
   logic [RW-1:0] val;

   always_comb begin
      sel = booth_sel(win);
      mag = '0;
      if (sel[BOOTH_ONE])      mag = {a_ext[WIDTH+1], a_ext};
      else if (sel[BOOTH_TWO]) mag = {a_ext, 1'b0};
      val = sel[BOOTH_NEG] ? (~mag + 1'b1) : mag;
      row = {{(2*WIDTH-RW){val[RW-1]}}, val};
   end

endmodule

// File: rtl/booth4_wallace_mult_pipe.sv
// -----------------------------------------------------------------------------
// booth4_wallace_mult_pipe
// Streaming 3-stage radix-4 Booth / Wallace-tree multiplier, signed or
// unsigned per transaction, valid/ready with full backpressure.
//   S1: operand extension, Booth recoding, NPP partial-product rows
//   S2: 3:2 carry-save reduction to sum/carry vectors
//   S3: carry-propagate add -> out_p
// Ports:
//   sys_clk, sys_rst_n         clock, async active-low reset
//   in_valid/in_ready          operand handshake (in_ready = global enable)
//   in_a, in_b [WIDTH-1:0]     multiplicand, multiplier (Booth-encoded)
//   in_signed                  1 = two's complement operands
//   in_acc                     (MULT_ACC_EN only) add product to accumulator
//   out_valid/out_ready        result handshake
//   out_p [PW-1:0]             product (holds when out_valid = 0)
// Optional feature macro: MULT_ACC_EN (adds in_acc and a PW-bit accumulator).
// -----------------------------------------------------------------------------
module booth4_wallace_mult_pipe
   import mult_pkg::*;
#(
   parameter  int WIDTH = 16,
   localparam int PW    = pw(WIDTH)
) (
   input  logic             sys_clk,
   input  logic             sys_rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic             in_signed,
`ifdef MULT_ACC_EN
   input  logic             in_acc,
`endif
   output logic             out_valid,
   input  logic             out_ready,
   output logic [PW-1:0]    out_p
);

   localparam int NPP = npp(WIDTH);
   localparam int XW  = WIDTH + 2;

   logic                    en;
   logic [3:1]              vld_q, vld_d;
   logic [XW-1:0]           a_ext, b_ext;
   logic [XW:0]             b_win;
   logic [NPP-1:0][PW-1:0]  pp_raw, pp_shift;
   logic [NPP-1:0][PW-1:0]  pp_q, pp_d;
   logic [PW-1:0]           csa_sum, csa_carry;
   logic [PW-1:0]           sum_q, sum_d, carry_q, carry_d;
   logic [PW-1:0]           prod;
   logic [PW-1:0]           out_q, out_d;
`ifdef MULT_ACC_EN
   logic                    acc1_q, acc1_d, acc2_q, acc2_d;
   logic [PW-1:0]           acc_q, acc_d;
`endif

   // ---------------- S1: extension + Booth rows ----------------
   always_comb begin
      a_ext = in_signed ? {{2{in_a[WIDTH-1]}}, in_a} : {2'b00, in_a};
      b_ext = in_signed ? {{2{in_b[WIDTH-1]}}, in_b} : {2'b00, in_b};
      // implicit b[-1] = 0 below the LSB
      b_win = {b_ext, 1'b0};
   end

   for (genvar i = 0; i < NPP; i++) begin : g_row
      booth4_pp_row #(.WIDTH(WIDTH)) u_row (
         .win   (b_win[2*i+2:2*i]),
         .a_ext (a_ext),
         .row   (pp_raw[i])
      );
      assign pp_shift[i] = pp_raw[i] << (2*i);
   end

   // ---------------- S2: Wallace reduction ----------------
   // Each level groups live rows in threes through 3:2 CSAs; leftovers pass
   // through. Row count shrinks ~2/3 per level until two rows remain. Reading
   // the three inputs before writing makes the in-place compaction safe
   // because the write index never runs ahead of the read index.
   logic [PW-1:0] rows [NPP];

   always_comb begin
      int n;
      int m;
      logic [PW-1:0] x, y, z;
      for (int i = 0; i < NPP; i++) rows[i] = pp_q[i];
      n = NPP;
      x = '0;
      y = '0;
      z = '0;
      for (int lvl = 0; lvl < NPP; lvl++) begin
         if (n > 2) begin
            m = 0;
            for (int k = 0; k < NPP; k += 3) begin
               if (k + 2 < n) begin
                  x           = rows[k];
                  y           = rows[k+1];
                  z           = rows[k+2];
                  rows[m]     = x ^ y ^ z;
                  rows[m+1]   = ((x & y) | (x & z) | (y & z)) << 1;
                  m           = m + 2;
               end else begin
                  if (k < n) begin
                     rows[m] = rows[k];
                     m       = m + 1;
                  end
                  if (k + 1 < n) begin
                     rows[m] = rows[k+1];
                     m       = m + 1;
                  end
               end
            end
            n = m;
         end
      end
      csa_sum   = rows[0];
      csa_carry = rows[1];
   end

   // ---------------- next-state / S3 ----------------
   always_comb begin
      en      = !(vld_q[3] && !out_ready);
      prod    = sum_q + carry_q;
      vld_d   = vld_q;
      pp_d    = pp_q;
      sum_d   = sum_q;
      carry_d = carry_q;
      out_d   = out_q;
`ifdef MULT_ACC_EN
      acc1_d  = acc1_q;
      acc2_d  = acc2_q;
      acc_d   = acc_q;
`endif
      if (en) begin
         vld_d = {vld_q[2:1], in_valid};
         if (in_valid) begin
            pp_d = pp_shift;
`ifdef MULT_ACC_EN
            acc1_d = in_acc;
`endif
         end
         if (vld_q[1]) begin
            sum_d   = csa_sum;
            carry_d = csa_carry;
`ifdef MULT_ACC_EN
            acc2_d  = acc1_q;
`endif
         end
         if (vld_q[2]) begin
`ifdef MULT_ACC_EN
            out_d = acc2_q ? (acc_q + prod) : prod;
            acc_d = out_d;
`else
            out_d = prod;
`endif
         end
      end
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         vld_q   <= '0;
         pp_q    <= '0;
         sum_q   <= '0;
         carry_q <= '0;
         out_q   <= '0;
`ifdef MULT_ACC_EN
         acc1_q  <= 1'b0;
         acc2_q  <= 1'b0;
         acc_q   <= '0;
`endif
      end else begin
         vld_q   <= vld_d;
         pp_q    <= pp_d;
         sum_q   <= sum_d;
         carry_q <= carry_d;
         out_q   <= out_d;
`ifdef MULT_ACC_EN
         acc1_q  <= acc1_d;
         acc2_q  <= acc2_d;
         acc_q   <= acc_d;
`endif
      end
   end

   assign in_ready  = en;
   assign out_valid = vld_q[3];
   assign out_p     = out_q;

endmodule

// File: tb/tb_booth4_wallace_mult_pipe.sv
// -----------------------------------------------------------------------------
// tb_booth4_wallace_mult_pipe
// Directed + random bench for booth4_wallace_mult_pipe (WIDTH=16).
// A negedge monitor pushes reference products on every input transfer and
// pops/compares on every output transfer. Define MULT_ACC_EN to also
// exercise the accumulator.
// -----------------------------------------------------------------------------
module tb_booth4_wallace_mult_pipe;

   localparam int W  = 16;
   localparam int PW = 32;

   logic          sys_clk   = 1'b0;
   logic          sys_rst_n = 1'b0;
   logic          in_valid  = 1'b0;
   logic          in_signed = 1'b0;
   logic          in_acc    = 1'b0;
   logic          out_ready = 1'b1;
   logic [W-1:0]  in_a      = '0;
   logic [W-1:0]  in_b      = '0;
   logic          in_ready;
   logic          out_valid;
   logic [PW-1:0] out_p;

   int            errors = 0;
   int            checks = 0;
   int            pushed = 0;
   logic [PW-1:0] exp_q[$];
   logic [PW-1:0] m_acc = '0;

   booth4_wallace_mult_pipe #(.WIDTH(W)) dut (
      .sys_clk   (sys_clk),
      .sys_rst_n (sys_rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_a      (in_a),
      .in_b      (in_b),
      .in_signed (in_signed),
`ifdef MULT_ACC_EN
      .in_acc    (in_acc),
`endif
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_p     (out_p)
   );

   always #5 sys_clk = ~sys_clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [PW-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic s);
      longint     sa, sb;
      logic [63:0] pv;
      sa = s ? longint'($signed(a)) : longint'({48'b0, a});
      sb = s ? longint'($signed(b)) : longint'({48'b0, b});
      pv = 64'(sa * sb);
      return pv[PW-1:0];
   endfunction

   // Scoreboard: pop before push so a same-cycle in/out pair stays ordered
   always @(negedge sys_clk) begin
      logic [PW-1:0] e;
      if (sys_rst_n) begin
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) chk("spurious_out", {63'b0, out_valid}, 64'd0);
            else begin
               e = exp_q.pop_front();
               chk("sb_out_p", {32'b0, out_p}, {32'b0, e});
            end
         end
         if (in_valid && in_ready) begin
            e = model(in_a, in_b, in_signed);
`ifdef MULT_ACC_EN
            if (in_acc) e = m_acc + e;
            m_acc = e;
`endif
            exp_q.push_back(e);
            pushed++;
         end
      end
   end

   // One isolated transfer; checks 3-cycle latency and exact product
   task automatic single(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                         input logic acc, input logic [PW-1:0] exp, input string tag);
      @(posedge sys_clk); #1;
      in_a = a; in_b = b; in_signed = s; in_acc = acc; in_valid = 1'b1;
      @(posedge sys_clk); #1;
      in_valid = 1'b0;
      chk({tag, "_lat1"}, {63'b0, out_valid}, 64'd0);
      @(posedge sys_clk); #1;
      chk({tag, "_lat2"}, {63'b0, out_valid}, 64'd0);
      @(posedge sys_clk); #1;
      chk({tag, "_lat3"}, {63'b0, out_valid}, 64'd1);
      chk({tag, "_p"}, {32'b0, out_p}, {32'b0, exp});
   endtask

   task automatic drain(input string tag);
      int guard;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      guard = 0;
      while (exp_q.size() != 0 && guard < 20) begin
         @(posedge sys_clk); #1;
         guard++;
      end
      chk(tag, 64'(exp_q.size()), 64'd0);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [W-1:0]  sa [8];
      logic [W-1:0]  sb [8];
      logic          ss [8];
      logic [PW-1:0] held;
      int            base, cyc;

      sa = '{16'h8000, 16'hFFFF, 16'h1234, 16'hFFFF, 16'h7FFF, 16'h0003, 16'hABCD, 16'h8000};
      sb = '{16'h8000, 16'hFFFF, 16'hFEDC, 16'h0001, 16'h7FFF, 16'hFFFD, 16'h0000, 16'hFFFF};
      ss = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};

      // reset state
      #2;
      chk("rst_out_valid", {63'b0, out_valid}, 64'd0);
      chk("rst_out_p", {32'b0, out_p}, 64'd0);
      repeat (2) @(posedge sys_clk);
      #1 sys_rst_n = 1'b1;
      #1 chk("rst_in_ready", {63'b0, in_ready}, 64'd1);

      // corner cases
      single(16'h8000, 16'h8000, 1'b1, 1'b0, 32'h40000000, "s_min_min");
      single(16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 32'h00000001, "s_m1_m1");
      single(16'hFFFF, 16'h0001, 1'b1, 1'b0, 32'hFFFFFFFF, "s_m1_p1");
      single(16'hFFFF, 16'hFFFF, 1'b0, 1'b0, 32'hFFFE0001, "u_max_max");
      single(16'h8000, 16'h0002, 1'b0, 1'b0, 32'h00010000, "u_8000_2");
      @(posedge sys_clk); #1;

      // back-to-back mixed stream: 8 results on 8 consecutive cycles
      for (int i = 0; i < 8; i++) begin
         in_a = sa[i]; in_b = sb[i]; in_signed = ss[i]; in_acc = 1'b0; in_valid = 1'b1;
         @(posedge sys_clk); #1;
         if (i >= 2) chk("stream_valid", {63'b0, out_valid}, 64'd1);
      end
      in_valid = 1'b0;
      @(posedge sys_clk); #1 chk("stream_valid", {63'b0, out_valid}, 64'd1);
      @(posedge sys_clk); #1 chk("stream_valid", {63'b0, out_valid}, 64'd1);
      @(posedge sys_clk); #1 chk("stream_end", {63'b0, out_valid}, 64'd0);
      drain("stream_drain");

      // backpressure: fill, then hold for 5 cycles with in_valid asserted
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         in_a = 16'($urandom); in_b = 16'($urandom); in_signed = 1'($urandom); in_valid = 1'b1;
         @(posedge sys_clk); #1;
      end
      held = out_p;
      for (int i = 0; i < 5; i++) begin
         chk("bp_in_ready", {63'b0, in_ready}, 64'd0);
         chk("bp_out_valid", {63'b0, out_valid}, 64'd1);
         chk("bp_hold", {32'b0, out_p}, {32'b0, held});
         in_a = 16'($urandom); in_b = 16'($urandom);
         @(posedge sys_clk); #1;
      end
      drain("bp_drain");

      // random traffic with random backpressure
      base = pushed;
      cyc  = 0;
      while (pushed - base < 1000 && cyc < 20000) begin
         in_a      = 16'($urandom);
         in_b      = 16'($urandom);
         in_signed = 1'($urandom);
         in_acc    = 1'($urandom);
         in_valid  = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 3) != 0);
         @(posedge sys_clk); #1;
         cyc++;
      end
      in_valid = 1'b0;
      in_acc   = 1'b0;
      chk("rand_count", 64'(pushed - base), 64'd1000);
      drain("rand_drain");

      // reset with 3 tokens in flight
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         in_a = sa[i]; in_b = sb[i]; in_signed = ss[i]; in_valid = 1'b1;
         @(posedge sys_clk); #1;
      end
      in_valid = 1'b0;
      #1 sys_rst_n = 1'b0;
      exp_q.delete();
      m_acc = '0;
      #1;
      chk("midrst_out_valid", {63'b0, out_valid}, 64'd0);
      chk("midrst_out_p", {32'b0, out_p}, 64'd0);
      @(posedge sys_clk); #1 sys_rst_n = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(posedge sys_clk); #1;
         chk("postrst_quiet", {63'b0, out_valid}, 64'd0);
      end

`ifdef MULT_ACC_EN
      single(16'd3, 16'd4, 1'b0, 1'b0, 32'd12, "acc_3x4");
      single(16'd5, 16'd6, 1'b0, 1'b1, 32'd42, "acc_5x6");
      single(16'hFFFE, 16'd7, 1'b1, 1'b1, 32'h0000001C, "acc_m2x7");
      drain("acc_drain");
`endif

      @(posedge sys_clk); #1;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/booth4_wallace_mult_pipe.md
Name: booth4_wallace_mult_pipe

Overview:
Parametrised, pipelined radix-4 Booth / Wallace-tree multiplier. It is the successor of the fixed 16x16 combinational signed multiplier.
- Width is generic.
- Signed or unsigned mode is selected per transaction.
- A valid/ready handshake with full backpressure is provided.
- It sits between operand producers (DSP datapath, FIR taps) and result consumers as a drop-in streaming multiply unit.

Parameters:
WIDTH, 16, operand width in bits; must be even and at least 4.
PW, 2*WIDTH, product width; derived, not overridable.

Ports:
sys_clk  input  1  clock, all state on rising edge
sys_rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operand pair present
in_ready  output  1  block can accept operands this cycle
in_a  input  WIDTH  multiplicand
in_b  input  WIDTH  multiplier (Booth-encoded operand)
in_signed  input  1  1 = two's-complement operands, 0 = unsigned
out_valid  output  1  result present
out_ready  input  1  consumer accepts result
out_p  output  PW  product

Behaviour:
- Reset: all stage valid bits 0, all data registers 0, out_valid=0, out_p=0. in_ready=1 once reset releases. Reset asserted mid-operation discards every in-flight token, with no partial output.
- Transfers: an input transfer occurs when in_valid && in_ready. An output transfer occurs when out_valid && out_ready.
- Pipeline, 3 register stages (S1, S2, S3), each with its own valid bit.
  - S1: operands extended to WIDTH+2 bits (sign-extend if in_signed, else zero-extend). Radix-4 Booth recoding gives NPP = WIDTH/2+1 digits in {-2,-1,0,+1,+2}. NPP partial-product rows are registered, each sign-extended to PW bits and shifted by 2*i.
  - S2: Wallace reduction with 3:2 carry-save adders down to two PW-bit vectors, registered.
  - S3: final carry-propagate add, registered to out_p. All arithmetic is modulo 2^PW; only the low PW bits are kept.
- Latency: exactly 3 cycles from input transfer to out_valid with no stall. Throughput is 1 result per cycle.
- Stall: global enable en = !(out_valid && !out_ready). When en=0 every stage holds its data and valid bits. in_ready = en, a combinational path from out_ready that is allowed.
- Bubbles: a stage with valid=0 may be overwritten while en=1. Bubbles are not compressed; the global stall holds them.
- in_signed travels with its token, so modes may change on every transfer.
- Data outputs of an invalid stage are don't-care, except out_p, which holds its last value when out_valid=0.
- Simultaneous input and output transfer in one cycle is legal and sustains full throughput.
- Corner cases:
  - signed min*min = 2^(PW-2) (no overflow).
  - unsigned max*max = 2^PW - 2^(WIDTH+1) + 1.

Optional Feature:
MULT_ACC_EN
- Defined:
  - Adds input port in_acc (1 bit, travels with its token) and a PW-bit accumulator register.
  - At S3: in_acc=1 gives out_p = acc + product (mod 2^PW). in_acc=0 gives out_p = product.
  - acc is loaded with the new out_p on every S3 load.
  - Reset clears acc to 0. A stall holds acc.
- Undefined: the port and register are absent and out_p = product.

Decomposition:
- Package mult_pkg holds:
  - Booth digit encoding localparams (neg, one, two select bits).
  - Function npp(width) = width/2+1.
  - Function pw(width) = 2*width.
- Sub-module booth4_pp_row (parameter WIDTH): takes a 3-bit Booth window and the extended multiplicand, returns one sign-extended partial-product row. It is instantiated NPP times in a generate loop.
- The CSA tree and final adder stay in the top module as generate logic.

Test Plan (WIDTH=16):
- Signed 0x8000*0x8000, in_signed=1 -> out_p=0x40000000 exactly 3 cycles after transfer. Signed 0xFFFF*0xFFFF -> 0x00000001. Signed 0xFFFF*0x0001 -> 0xFFFFFFFF.
- Unsigned 0xFFFF*0xFFFF, in_signed=0 -> 0xFFFE0001. Unsigned 0x8000*0x0002 -> 0x00010000.
- Back-to-back stream of 8 mixed signed/unsigned pairs with out_ready=1 -> 8 correct results on 8 consecutive cycles, in order.
- Backpressure: hold out_ready=0 for 5 cycles with in_valid=1 -> in_ready=0 while out_valid=1. Products are held stable, with no loss or duplication after release. 1000 random pairs with random in_valid/out_ready are checked against a reference model.
- Reset: assert sys_rst_n=0 with 3 tokens in flight -> out_valid=0 and out_p=0 immediately. No stale result appears after release.
- MULT_ACC_EN: 3*4 (acc=0), then 5*6 (acc=1), then -2*7 signed (acc=1) -> out_p = 12, 42, 28 (0x0000001C).
